// File: rtl/hpdc_spm_responder.sv
// Scratchpad responder for the HPDCache requester port: round-robin arbiter, tag stage, response stage.
// Optional HPDC_SPM_RANDSTALL_EN adds LFSR-driven random backpressure on req_ready_o.
module hpdc_spm_responder #(
   parameter int unsigned NREQ     = 2,
   parameter int unsigned OFFSET_W = 12,
   parameter int unsigned TAG_W    = 28,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned SID_W    = 3,
   parameter int unsigned TID_W    = 6
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NREQ-1:0]           req_valid_i,
   output logic [NREQ-1:0]           req_ready_o,
   input  logic [NREQ-1:0]           req_op_i,
   input  logic [NREQ*OFFSET_W-1:0]  req_offset_i,
   input  logic [NREQ*64-1:0]        req_wdata_i,
   input  logic [NREQ*8-1:0]         req_be_i,
   input  logic [NREQ*SID_W-1:0]     req_sid_i,
   input  logic [NREQ*TID_W-1:0]     req_tid_i,
   input  logic [NREQ-1:0]           req_need_rsp_i,
   input  logic [NREQ*TAG_W-1:0]     req_tag_i,
   input  logic [NREQ-1:0]           req_abort_i,
   output logic [NREQ-1:0]           rsp_valid_o,
   output logic [63:0]               rsp_rdata_o,
   output logic [SID_W-1:0]          rsp_sid_o,
   output logic [TID_W-1:0]          rsp_tid_o,
   output logic                      rsp_error_o,
   output logic                      wbuf_empty_o
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PAW = TAG_W + OFFSET_W;

   logic [OFFSET_W-1:0] w_offset [NREQ];
   logic [63:0]         w_wdata  [NREQ];
   logic [7:0]          w_be     [NREQ];
   logic [SID_W-1:0]    w_sid    [NREQ];
   logic [TID_W-1:0]    w_tid    [NREQ];
   logic [TAG_W-1:0]    w_tag    [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_offset[g] = req_offset_i[g*OFFSET_W +: OFFSET_W];
      assign w_wdata[g]  = req_wdata_i[g*64 +: 64];
      assign w_be[g]     = req_be_i[g*8 +: 8];
      assign w_sid[g]    = req_sid_i[g*SID_W +: SID_W];
      assign w_tid[g]    = req_tid_i[g*TID_W +: TID_W];
      assign w_tag[g]    = req_tag_i[g*TAG_W +: TAG_W];
   end

   logic w_stall;
`ifdef HPDC_SPM_RANDSTALL_EN
   logic [15:0] r_lfsr;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_lfsr <= 16'hACE1;
      else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end
   assign w_stall = r_lfsr[0];
`else
   assign w_stall = 1'b0;
`endif

   // S0: first valid port after the round-robin pointer
   logic [PW-1:0] r_rr_ptr;
   logic [PW-1:0] w_grant;
   logic          w_grant_vld;
   logic [PW:0]   w_cand;
   logic          w_accept;

   always_comb begin
      w_grant     = r_rr_ptr;
      w_grant_vld = 1'b0;
      w_cand      = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         w_cand = {1'b0, r_rr_ptr} + (PW+1)'(i);
         if (w_cand >= (PW+1)'(NREQ)) w_cand = w_cand - (PW+1)'(NREQ);
         if (!w_grant_vld && req_valid_i[w_cand[PW-1:0]]) begin
            w_grant     = w_cand[PW-1:0];
            w_grant_vld = 1'b1;
         end
      end
   end

   assign w_accept = w_grant_vld && !w_stall && !rst_i;

   always_comb begin
      req_ready_o = '0;
      if (w_accept) req_ready_o[w_grant] = 1'b1;
   end

   logic                r_s1_vld;
   logic                r_s1_op;
   logic [OFFSET_W-1:0] r_s1_offset;
   logic [63:0]         r_s1_wdata;
   logic [7:0]          r_s1_be;
   logic [SID_W-1:0]    r_s1_sid;
   logic [TID_W-1:0]    r_s1_tid;
   logic                r_s1_need_rsp;
   logic [PW-1:0]       r_s1_port;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rr_ptr      <= PW'(NREQ - 1);
         r_s1_vld      <= 1'b0;
         r_s1_op       <= 1'b0;
         r_s1_offset   <= '0;
         r_s1_wdata    <= '0;
         r_s1_be       <= '0;
         r_s1_sid      <= '0;
         r_s1_tid      <= '0;
         r_s1_need_rsp <= 1'b0;
         r_s1_port     <= '0;
      end else begin
         r_s1_vld <= w_accept;
         if (w_accept) begin
            r_rr_ptr      <= w_grant;
            r_s1_op       <= req_op_i[w_grant];
            r_s1_offset   <= w_offset[w_grant];
            r_s1_wdata    <= w_wdata[w_grant];
            r_s1_be       <= w_be[w_grant];
            r_s1_sid      <= w_sid[w_grant];
            r_s1_tid      <= w_tid[w_grant];
            r_s1_need_rsp <= req_need_rsp_i[w_grant];
            r_s1_port     <= w_grant;
         end
      end
   end

   // S1: physical tag and abort arrive from the owning port this cycle
   logic [63:0]    r_mem [DEPTH];
   logic [PAW-1:0] w_pa;
   logic [AW-1:0]  w_widx;
   logic           w_oor;
   logic           w_abort;
   logic [63:0]    w_rd_word;
   logic [63:0]    w_merged;
   logic           w_wr_en;
   logic           w_rsp_fire;
   logic [NREQ-1:0] w_rsp_vec;

   assign w_pa      = {w_tag[r_s1_port], r_s1_offset};
   assign w_oor     = (w_pa >= PAW'(DEPTH * 8));
   assign w_widx    = w_pa[AW+2:3];
   assign w_abort   = req_abort_i[r_s1_port];
   // Only one request occupies S1, so a same-word store never overlaps a load here.
   assign w_rd_word = r_mem[w_widx];

   always_comb begin
      w_merged = w_rd_word;
      for (int unsigned b = 0; b < 8; b++) begin
         if (r_s1_be[b]) w_merged[8*b +: 8] = r_s1_wdata[8*b +: 8];
      end
   end

   assign w_wr_en    = r_s1_vld && r_s1_op && !w_abort && !w_oor;
   assign w_rsp_fire = r_s1_vld && !w_abort && (!r_s1_op || r_s1_need_rsp);

   always_ff @(posedge clk_i) begin
      if (w_wr_en) r_mem[w_widx] <= w_merged;
   end

   always_comb begin
      w_rsp_vec = '0;
      if (w_rsp_fire) w_rsp_vec[r_s1_port] = 1'b1;
   end

   // S2: response register, fields held between responses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_o <= '0;
         rsp_rdata_o <= '0;
         rsp_sid_o   <= '0;
         rsp_tid_o   <= '0;
         rsp_error_o <= 1'b0;
      end else begin
         rsp_valid_o <= w_rsp_vec;
         if (w_rsp_fire) begin
            rsp_rdata_o <= (r_s1_op || w_oor) ? 64'h0 : w_rd_word;
            rsp_sid_o   <= r_s1_sid;
            rsp_tid_o   <= r_s1_tid;
            rsp_error_o <= w_oor;
         end
      end
   end

   assign wbuf_empty_o = !(r_s1_vld && r_s1_op);

endmodule
